if_id_queue: RTL
================

Name: if_id_queue

Overview:
- Two-entry (parameterisable) instruction queue directly downstream of the fetch unit; consumes fetch-stage {PC, Instr} pairs and feeds the decode/controller stage.
- Decouples fetch from decode stalls with a valid/ready handshake on both sides.
- Flushes on control-flow redirect.
- Tags each entry with an instruction-address fault flag and supplies PC+8 for link writes (jal/jalr/bnezalc).

Parameters:
DEPTH, 2, number of queue entries; power of two, 2 or 4
IM_BASE, 32'h0000_3000, first valid instruction address
IM_WORDS, 4096, instruction memory size in words
PC_RESET, 32'h0000_3000, out_pc value when the queue is empty

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  fetch presents a valid {in_pc, in_instr}
in_ready  output  1  queue can accept this cycle
in_pc  input  32  PC of the fetched instruction
in_instr  input  32  fetched instruction word
flush  input  1  synchronous discard of all entries, e.g. taken branch/jump redirect
out_valid  output  1  head entry valid
out_ready  input  1  decode consumes the head this cycle
out_pc  output  32  head PC
out_instr  output  32  head instruction
out_pc8  output  32  head PC + 8, link value
out_adel  output  1  head PC misaligned or outside instruction memory
count  output  clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: asserted while reset==0, takes effect without waiting for clk.
  - count=0, head/tail pointers=0, entry flags cleared.
  - out_valid=0, in_ready=0 while reset is low; in_ready=1 from release.
  - Storage contents are don't-care.
- Push: in_valid && in_ready at a clk edge. Writes {in_pc, in_instr, adel} at tail; tail increments modulo DEPTH.
- Pop: out_valid && out_ready at a clk edge. Head increments modulo DEPTH.
- in_ready = (count < DEPTH). No combinational path from out_ready, so a full queue refuses a push even if a pop occurs the same cycle.
- No fall-through: a pushed entry is visible on out_* from the next cycle. Minimum latency is 1 cycle.
- Simultaneous push and pop with 0 < count < DEPTH: count unchanged, both pointers advance.
- Empty: out_valid=0, out_instr=32'h0000_0000 (NOP), out_pc=PC_RESET, out_pc8=PC_RESET+8, out_adel=0.
- flush=1 at an edge:
  - count:=0 and pointers:=0.
  - Takes priority over a same-cycle push and pop; the offered push is dropped and the pop does not occur.
  - Flush while empty is a no-op.
- adel is computed at push: in_pc[1:0]!=0 OR in_pc < IM_BASE OR in_pc >= IM_BASE + 4*IM_WORDS. Unsigned 32-bit compare; the bound is computed in 33 bits to avoid wrap.
- out_pc8 = out_pc + 32'd8, modulo 2^32, combinational from the head.
- count is never > DEPTH.
- Pointer wrap uses the low clog2(DEPTH) bits only.
- Reset mid-transfer: all entries lost; the handshake restarts with in_ready rising after release.
- Status outputs (out_*, in_ready, count) derive only from registered state. No combinational in→out path exists except the in_ready dependency on count.

Decomposition:
- Shared package (mips_defs): IM_BASE, IM_WORDS, PC_RESET, NOP_INSTR (32'h0), and the queue entry typedef {pc[31:0], instr[31:0], adel}.
- One natural sub-module: fetch_addr_check, purely combinational in_pc → adel, reusable by a later data-address exception unit.
- Pointer/count logic stays in if_id_queue.

Test Plan:
- Reset low mid-run with 2 entries held → immediately out_valid=0, out_instr=0, out_pc=0x3000, count=0; after release in_ready=1.
- Push pc=0x3000 instr=0x3C011234, out_ready=0 → next cycle out_valid=1, out_pc=0x3000, out_instr=0x3C011234, out_pc8=0x3008, count=1.
- Push 0x3000, 0x3004 with out_ready=0 → count=2, in_ready=0. Offer 0x3008 with out_ready=1 → 0x3008 not accepted; head becomes 0x3004, count=1.
- Streaming: in_valid=out_ready=1 for 10 cycles with pc 0x3000+4k → outputs in order one cycle late, count stays 1, pointers wrap correctly.
- flush=1 with count=2 and in_valid=1 (pc 0x3010) → next cycle count=0, out_valid=0; 0x3010 never appears.
- Push pc=0x3002 → out_adel=1. Push pc=0x2FFC → out_adel=1. Push pc=0x6FFC → out_adel=0. Push pc=0x7000 → out_adel=1. Push pc=0xFFFFFFFC → out_adel=1, out_pc8=0x00000004.

Source files
------------

// File: rtl/mips_defs.sv
// Shared fetch/decode definitions: instruction memory map, reset PC and the
// instruction queue entry layout.
package mips_defs;

  localparam logic [31:0] IM_BASE   = 32'h0000_3000;
  localparam int          IM_WORDS  = 4096;
  localparam logic [31:0] PC_RESET  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } if_entry_t;

endpackage

// File: rtl/fetch_addr_check.sv
// Instruction-address fault check: flags PCs that are misaligned or fall
// outside the instruction memory window.
module fetch_addr_check #(
  parameter logic [31:0] IM_BASE  = mips_defs::IM_BASE,
  parameter int          IM_WORDS = mips_defs::IM_WORDS
) (
  input  logic [31:0] pc,
  output logic        adel
);

  // Upper bound held in 33 bits so a window ending at 2^32 does not wrap to 0.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  assign adel = (pc[1:0] != 2'b00) || (pc < IM_BASE) || ({1'b0, pc} >= IM_LIMIT);

endmodule

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: registered valid/ready FIFO between fetch and
// decode, with redirect flush, per-entry address fault tag and PC+8 link value.
module if_id_queue #(
  parameter int          DEPTH    = 2,
  parameter logic [31:0] IM_BASE  = mips_defs::IM_BASE,
  parameter int          IM_WORDS = mips_defs::IM_WORDS,
  parameter logic [31:0] PC_RESET = mips_defs::PC_RESET
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [31:0]              out_pc8,
  output logic                     out_adel,
  output logic [$clog2(DEPTH):0]   count
);
  import mips_defs::*;

  localparam int             PW      = $clog2(DEPTH);
  localparam int             CW      = PW + 1;
  localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  if_entry_t     mem [DEPTH];
  if_entry_t     head_e;
  logic          in_adel;
  logic          push;
  logic          pop;

  fetch_addr_check #(
    .IM_BASE  (IM_BASE),
    .IM_WORDS (IM_WORDS)
  ) u_addr_check (
    .pc   (in_pc),
    .adel (in_adel)
  );

  // Ready depends only on occupancy (and the reset pin), never on out_ready.
  assign in_ready  = reset && (cnt < DEPTH_C);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[tail] <= {in_pc, in_instr, in_adel};
  end

  assign head_e = mem[head];

  always_comb begin
    out_pc    = PC_RESET;
    out_instr = NOP_INSTR;
    out_adel  = 1'b0;
    if (out_valid) begin
      out_pc    = head_e.pc;
      out_instr = head_e.instr;
      out_adel  = head_e.adel;
    end
  end

  assign out_pc8 = out_pc + 32'd8;

endmodule
